// File: rtl/clk_div_pkg.sv
// Shared constants for the programmable tick/clock generator family.
package clk_div_pkg;

    localparam logic MODE_TOGGLE = 1'b0;
    localparam logic MODE_PULSE  = 1'b1;

    localparam int unsigned SYS_CLK_HZ = 50_000_000;
    localparam int unsigned DEF_DIV    = 2_500_000;

    // Half-period divisor that makes a toggle-mode channel run at f Hz.
    function automatic int unsigned div_for_hz(input int unsigned f);
        return SYS_CLK_HZ / (2 * f);
    endfunction

endpackage

// File: rtl/tick_gen_ch.sv
// One tick/clock channel: period counter, active and pending divisor,
// latched mode, and registered clk_out/tick.
module tick_gen_ch
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned RST_DIV = DEF_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_in,
    input  logic             phase_sync,
    output logic             clk_out,
    output logic             tick
);

    localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(RST_DIV);

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] div_r_q, div_r_d;
    logic [CNT_W-1:0] div_pend_q, div_pend_d;
    logic             pend_v_q, pend_v_d;
    logic             mode_r_q, mode_r_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;

    logic [CNT_W-1:0] div_clean;
    logic [CNT_W-1:0] div_next;
    logic             at_end;

    // A zero divisor would never wrap, so it is treated as the fastest rate.
    assign div_clean = (div_in == '0) ? ONE : div_in;
    assign at_end    = (count_q == div_r_q - ONE);

    // Next-state: sync beats disable beats the normal counting path.
    always_comb begin
        count_d    = count_q;
        div_r_d    = div_r_q;
        div_pend_d = div_pend_q;
        pend_v_d   = pend_v_q;
        mode_r_d   = mode_r_q;
        clk_out_d  = clk_out_q;
        tick_d     = 1'b0;

        // Divisor that takes over at any period boundary; a load in the
        // same cycle is the most recent value and wins over a pending one.
        div_next = pend_v_q ? div_pend_q : div_r_q;
        if (div_load) begin
            div_next = div_clean;
        end

        if (phase_sync) begin
            count_d   = '0;
            clk_out_d = 1'b0;
            div_r_d   = div_next;
            pend_v_d  = 1'b0;
        end else if (!en) begin
            count_d   = '0;
            clk_out_d = 1'b0;
            mode_r_d  = mode;
            div_r_d   = div_next;
            pend_v_d  = 1'b0;
        end else if (at_end) begin
            count_d   = '0;
            tick_d    = 1'b1;
            clk_out_d = (mode_r_q == MODE_PULSE) ? 1'b1 : ~clk_out_q;
            div_r_d   = div_next;
            pend_v_d  = 1'b0;
        end else begin
            count_d   = count_q + ONE;
            clk_out_d = (mode_r_q == MODE_PULSE) ? 1'b0 : clk_out_q;
            // Mid-period loads wait for the wrap so no period is cut short.
            if (div_load) begin
                div_pend_d = div_clean;
                pend_v_d   = 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q    <= '0;
            div_r_q    <= DIV_RST;
            div_pend_q <= DIV_RST;
            pend_v_q   <= 1'b0;
            mode_r_q   <= MODE_TOGGLE;
            clk_out_q  <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            count_q    <= count_d;
            div_r_q    <= div_r_d;
            div_pend_q <= div_pend_d;
            pend_v_q   <= pend_v_d;
            mode_r_q   <= mode_r_d;
            clk_out_q  <= clk_out_d;
            tick_q     <= tick_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;

endmodule

// File: rtl/tick_gen_multi.sv
// Multi-channel programmable tick/clock generator; one tick_gen_ch per
// channel with shared reset and phase_sync.
module tick_gen_multi #(
    parameter int unsigned NCH     = 2,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned DEF_DIV = clk_div_pkg::DEF_DIV
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       en,
    input  logic [NCH-1:0]       mode,
    input  logic [NCH-1:0]       div_load,
    input  logic [NCH*CNT_W-1:0] div_in,
    input  logic                 phase_sync,
    output logic [NCH-1:0]       clk_out,
    output logic [NCH-1:0]       tick
);

    import clk_div_pkg::*;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        tick_gen_ch #(
            .CNT_W   (CNT_W),
            .RST_DIV (DEF_DIV)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .en         (en[i]),
            .mode       (mode[i]),
            .div_load   (div_load[i]),
            .div_in     (div_in[i*CNT_W +: CNT_W]),
            .phase_sync (phase_sync),
            .clk_out    (clk_out[i]),
            .tick       (tick[i])
        );
    end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Scoreboard bench for tick_gen_multi: stimulus pushes model predictions,
// a monitor pops and compares them one cycle at a time.
module tb_tick_gen_multi;

    localparam int NCH   = 2;
    localparam int CNT_W = 32;
    localparam int DEFD  = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NCH-1:0]       en;
    logic [NCH-1:0]       mode;
    logic [NCH-1:0]       div_load;
    logic [NCH*CNT_W-1:0] div_in;
    logic                 phase_sync;
    logic [NCH-1:0]       clk_out;
    logic [NCH-1:0]       tick;

    tick_gen_multi #(.NCH(NCH), .CNT_W(CNT_W), .DEF_DIV(DEFD)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .div_load   (div_load),
        .div_in     (div_in),
        .phase_sync (phase_sync),
        .clk_out    (clk_out),
        .tick       (tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NCH-1:0] co;
        logic [NCH-1:0] tk;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    // Reference model: cycles elapsed in the current period, the divisor
    // governing it, an optional waiting divisor, and the output levels.
    int m_elapsed[NCH];
    int m_div[NCH];
    int m_pend[NCH];
    bit m_pulse[NCH];
    bit m_out[NCH];
    bit m_tick[NCH];

    function automatic int san(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    task automatic step(input bit r, input bit [1:0] e, input bit [1:0] m,
                        input bit [1:0] ld, input int d0, input int d1,
                        input bit s);
        int   dv[NCH];
        exp_t x;
        @(negedge clk);
        rst        = r;
        en         = e;
        mode       = m;
        div_load   = ld;
        div_in     = {32'(d1), 32'(d0)};
        phase_sync = s;
        dv[0] = d0;
        dv[1] = d1;
        for (int c = 0; c < NCH; c++) begin
            int upcoming;
            upcoming = ld[c] ? san(dv[c]) : ((m_pend[c] >= 0) ? m_pend[c] : m_div[c]);
            if (!r) begin
                m_elapsed[c] = 0; m_div[c] = DEFD; m_pend[c] = -1;
                m_pulse[c] = 0; m_out[c] = 0; m_tick[c] = 0;
            end else if (s || !e[c]) begin
                m_elapsed[c] = 0; m_out[c] = 0; m_tick[c] = 0;
                m_div[c] = upcoming; m_pend[c] = -1;
                if (!s) m_pulse[c] = m[c];
            end else if (m_elapsed[c] + 1 >= m_div[c]) begin
                m_elapsed[c] = 0; m_tick[c] = 1;
                m_out[c] = m_pulse[c] ? 1'b1 : !m_out[c];
                m_div[c] = upcoming; m_pend[c] = -1;
            end else begin
                m_elapsed[c]++; m_tick[c] = 0;
                if (m_pulse[c]) m_out[c] = 0;
                if (ld[c]) m_pend[c] = san(dv[c]);
            end
            x.co[c] = m_out[c];
            x.tk[c] = m_tick[c];
        end
        exp_q.push_back(x);
    endtask

    // Monitor: after each active edge, compare outputs with the next prediction.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (clk_out !== e.co || tick !== e.tk)
                $display("FAIL outputs @%0t: clk_out=%b tick=%b, required clk_out=%b tick=%b",
                         $time, clk_out, tick, e.co, e.tk);
            else
                passed++;
        end
    end

    initial begin
        bit [1:0] ren;
        int       guard;
        rst = 1'b0; en = '0; mode = '0; div_load = '0; div_in = '0; phase_sync = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            m_elapsed[c] = 0; m_div[c] = DEFD; m_pend[c] = -1;
            m_pulse[c] = 0; m_out[c] = 0; m_tick[c] = 0;
        end

        // Reset and default rate.
        repeat (3) step(0, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        step(1, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        repeat (20) step(1, 2'b11, 2'b00, 2'b00, 0, 0, 0);

        // Pulse mode on ch0 with divisor 5; mode wiggles while enabled.
        step(1, 2'b00, 2'b01, 2'b01, 5, 0, 0);
        repeat (20) step(1, 2'b01, 2'($urandom_range(0, 3)), 2'b00, 0, 0, 0);

        // Glitch-free reload on ch1: 10 then 3 mid-period, then at a wrap.
        step(1, 2'b00, 2'b00, 2'b10, 0, 10, 0);
        repeat (3) step(1, 2'b10, 2'b00, 2'b00, 0, 0, 0);
        step(1, 2'b10, 2'b00, 2'b10, 0, 3, 0);
        repeat (15) step(1, 2'b10, 2'b00, 2'b00, 0, 0, 0);
        step(1, 2'b10, 2'b00, 2'b10, 0, 10, 0);
        guard = 0;
        while (m_elapsed[1] + 1 != m_div[1] && guard < 40) begin
            step(1, 2'b10, 2'b00, 2'b00, 0, 0, 0);
            guard++;
        end
        step(1, 2'b10, 2'b00, 2'b10, 0, 3, 0);
        repeat (12) step(1, 2'b10, 2'b00, 2'b00, 0, 0, 0);

        // Zero divisor: ch0 toggle (clk/2), ch1 pulse (held high).
        step(1, 2'b00, 2'b10, 2'b11, 0, 0, 0);
        repeat (10) step(1, 2'b11, 2'b10, 2'b00, 0, 0, 0);

        // Phase sync with divisors 6 and 9 running out of phase.
        step(1, 2'b00, 2'b00, 2'b11, 6, 9, 0);
        repeat (3) step(1, 2'b01, 2'b00, 2'b00, 0, 0, 0);
        repeat (7) step(1, 2'b11, 2'b00, 2'b00, 0, 0, 0);
        step(1, 2'b11, 2'b00, 2'b00, 0, 0, 1);
        repeat (22) step(1, 2'b11, 2'b00, 2'b00, 0, 0, 0);

        // Reset with a pending load and clk_out high, then default rate.
        step(1, 2'b11, 2'b00, 2'b11, 2, 2, 0);
        step(0, 2'b11, 2'b00, 2'b00, 0, 0, 0);
        repeat (12) step(1, 2'b11, 2'b00, 2'b00, 0, 0, 0);

        // Randomised traffic.
        ren = 2'b11;
        for (int i = 0; i < 3000; i++) begin
            bit [1:0] ld;
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 39) == 0) ren[c] = ~ren[c];
                ld[c] = ($urandom_range(0, 11) == 0);
            end
            step($urandom_range(0, 499) != 0, ren, 2'($urandom_range(0, 3)), ld,
                 int'($urandom_range(0, 12)), int'($urandom_range(0, 12)),
                 $urandom_range(0, 99) == 0);
        end

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d predictions left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
